l2_request_scheduler: RTL and testbench
=======================================

# l2_request_scheduler

Shares the single L2-side memory port between the instruction cache, the data cache and a prefetch requester. It sits between the cache miss paths and the L2 cache. It latches the winning request, holds it stable on the L2 port until the L2 responds, then routes the response back to the owner. Demand traffic always beats prefetch; a starvation counter guarantees instruction fetches progress under a stream of data misses.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while I waits before I is forced; legal 1–15.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- i_pmem_read  in  1  icache line read request
- i_pmem_address  in  32  icache line address
- i_pmem_rdata  out  256  line to icache
- i_pmem_resp  out  1  icache completion
- d_pmem_read  in  1  dcache line read request
- d_pmem_write  in  1  dcache line write request
- d_pmem_address  in  32  dcache line address
- d_pmem_wdata  in  256  dcache write line
- d_pmem_rdata  out  256  line to dcache
- d_pmem_resp  out  1  dcache completion
- pf_read  in  1  prefetch read request
- pf_address  in  32  prefetch line address
- pf_resp  out  1  prefetch completion (data discarded; L2 fills itself)
- l2_read, l2_write  out  1  L2 request strobes
- l2_address  out  32  L2 address
- l2_wdata  out  256  L2 write line
- l2_rdata  in  256  L2 read line
- l2_resp  in  1  L2 completion, one-cycle pulse
- grant_owner  out  2  0 none, 1 I, 2 D, 3 PF

## Operation
- States: IDLE, BUSY_I, BUSY_D, BUSY_PF.
- IDLE: evaluate requests. Priority is D > I > PF, except that I wins when starve_cnt == STARVE_LIMIT and i_pmem_read=1. The winner's op, address and wdata are captured into a request latch, and the FSM moves to the matching BUSY state. With no request, stay in IDLE.
- BUSY_x:
  - l2_read/l2_write/l2_address/l2_wdata are driven only from the latch; requester inputs are not sampled.
  - On l2_resp: the owner's *_resp is 1 that cycle and its *_rdata = l2_rdata (combinational pass-through); next state is IDLE.
  - Non-owner resp is 0 and its rdata is 0.
- Requesters hold their request until their resp. Each request produces exactly one resp.
- d_pmem_read and d_pmem_write asserted together: treated as a write.
- starve_cnt, $clog2(STARVE_LIMIT+1) bits, updated on D grants, saturating at STARVE_LIMIT:
  - D grant with i_pmem_read=1: increment.
  - D grant with i_pmem_read=0: clear.
- starve_cnt on other grants:
  - I grant: clear.
  - PF grant: unchanged.
- l2_resp in IDLE is ignored.
- grant_owner reflects the current state (0 in IDLE).

## Timing
- Reset values: state IDLE, latch 0, starve_cnt 0.
- All outputs are 0 under reset: l2_read, l2_write, l2_address, l2_wdata, all *_resp, all *_rdata, and grant_owner.
- Request visible in IDLE at cycle T: l2 strobe, address and data asserted from cycle T+1.
- l2_resp at cycle T+1+k (k≥0): owner resp in the same cycle. IDLE at T+2+k; the next grant's strobe appears at T+3+k at the earliest.
- Arbitration overhead is 2 cycles per transaction beyond L2 latency; no back-to-back strobes.
- Requests arriving in the same cycle are resolved by priority only. A losing request stays pending and is evaluated again at the next IDLE.
- Reset asserted mid-transaction: next cycle is IDLE, strobes drop, and the outstanding L2 transaction is abandoned with no resp to its owner. The L2 is reset by the same signal.

## Configuration
- PREFETCH_PORT_EN defined: PF requester, BUSY_PF state and grant_owner=3 are compiled in.
- PREFETCH_PORT_EN undefined:
  - Ports are still present; pf_read is ignored and pf_resp is tied 0.
  - BUSY_PF is unreachable, and grant_owner never equals 3.

## Test plan
- Single I read of 0x0000_1000, L2 latency 3:
  - l2_read=1 and l2_address=0x1000 from T+1.
  - i_pmem_resp=1 at T+4 with i_pmem_rdata equal to l2_rdata; d_pmem_resp stays 0.
- D write of 0x8000_0040 (wdata pattern 0xA5 repeated), pf_read of 0x2000 and i_pmem_read of 0x1000 all at T:
  - First grant D: l2_write=1 with the latched wdata.
  - Then I, then PF (when PREFETCH_PORT_EN is defined); exactly three resps, in that order.
- STARVE_LIMIT=4, i_pmem_read held, D re-requesting every IDLE: D granted 4 times, then I granted on the 5th arbitration, then starve_cnt=0.
- pf_read held with demand requests injected every IDLE: PF is never granted until both i_pmem_read and d_pmem_read/d_pmem_write are 0.
- Reset pulsed in BUSY_D two cycles after the strobe:
  - Next cycle all outputs are 0 and grant_owner=0.
  - The late l2_resp is ignored and produces no d_pmem_resp.
- Build without PREFETCH_PORT_EN, pf_read=1 with pf_address=0x3000: no L2 strobe and pf_resp=0 for 20 cycles.

Source files
------------

// File: rtl/l2_request_scheduler.sv
// Arbitrates the single L2 memory port between icache, dcache and prefetch misses.
// Optional prefetch requester is compiled in with `define PREFETCH_PORT_EN.
module l2_request_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  input  logic         pf_read,
  input  logic [31:0]  pf_address,
  output logic         pf_resp,
  output logic         l2_read,
  output logic         l2_write,
  output logic [31:0]  l2_address,
  output logic [255:0] l2_wdata,
  input  logic [255:0] l2_rdata,
  input  logic         l2_resp,
  output logic [1:0]   grant_owner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // State encoding doubles as the grant_owner code.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_I  = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;
  localparam logic [1:0] BUSY_PF = 2'd3;

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } req_t;

  logic [1:0]    state, nxt_state;
  req_t          lat, nxt_lat;
  logic [SW-1:0] starve_cnt, nxt_starve;
  logic          d_req, i_force, live;

  assign d_req   = d_pmem_read | d_pmem_write;
  assign i_force = i_pmem_read && (starve_cnt == LIMIT);

`ifndef PREFETCH_PORT_EN
  wire unused_pf = ^{pf_read, pf_address};
`endif

  always_comb begin
    nxt_state  = state;
    nxt_lat    = lat;
    nxt_starve = starve_cnt;
    case (state)
      IDLE: begin
        if (i_force || (!d_req && i_pmem_read)) begin
          nxt_state     = BUSY_I;
          nxt_lat.rd    = 1'b1;
          nxt_lat.wr    = 1'b0;
          nxt_lat.addr  = i_pmem_address;
          nxt_lat.wdata = '0;
          nxt_starve    = '0;
        end else if (d_req) begin
          // read+write together is a write
          nxt_state     = BUSY_D;
          nxt_lat.rd    = ~d_pmem_write;
          nxt_lat.wr    = d_pmem_write;
          nxt_lat.addr  = d_pmem_address;
          nxt_lat.wdata = d_pmem_wdata;
          if (!i_pmem_read)
            nxt_starve = '0;
          else if (starve_cnt != LIMIT)
            nxt_starve = starve_cnt + 1'b1;
        end
`ifdef PREFETCH_PORT_EN
        else if (pf_read) begin
          nxt_state     = BUSY_PF;
          nxt_lat.rd    = 1'b1;
          nxt_lat.wr    = 1'b0;
          nxt_lat.addr  = pf_address;
          nxt_lat.wdata = '0;
        end
`endif
      end
      default: begin
        if (l2_resp) begin
          nxt_state = IDLE;
          nxt_lat   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat        <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= nxt_state;
      lat        <= nxt_lat;
      starve_cnt <= nxt_starve;
    end
  end

  // Outputs are forced quiet while reset is held, not just after it is sampled.
  assign live        = (state != IDLE) && !reset;
  assign grant_owner = reset ? IDLE : state;
  assign l2_read     = live & lat.rd;
  assign l2_write    = live & lat.wr;
  assign l2_address  = live ? lat.addr : '0;
  assign l2_wdata    = live ? lat.wdata : '0;

  assign i_pmem_resp  = live && (state == BUSY_I) && l2_resp;
  assign d_pmem_resp  = live && (state == BUSY_D) && l2_resp;
  assign i_pmem_rdata = i_pmem_resp ? l2_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? l2_rdata : '0;
`ifdef PREFETCH_PORT_EN
  assign pf_resp = live && (state == BUSY_PF) && l2_resp;
`else
  assign pf_resp = 1'b0;
`endif

endmodule

// File: tb/tb_l2_request_scheduler.sv
// Bench for l2_request_scheduler: vector table, directed corner sequences and
// randomized transactions against a transaction-level arbitration model.
module tb_l2_request_scheduler;
  localparam int LIMIT = 4;
`ifdef PREFETCH_PORT_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif
  localparam logic [31:0]  IA = 32'h0000_1000;
  localparam logic [31:0]  DA = 32'h8000_0040;
  localparam logic [31:0]  PA = 32'h0000_2000;
  localparam logic [255:0] WD = {32{8'hA5}};

  logic clk, reset;
  logic i_pmem_read, d_pmem_read, d_pmem_write, pf_read, l2_resp;
  logic [31:0] i_pmem_address, d_pmem_address, pf_address;
  logic [255:0] d_pmem_wdata, l2_rdata;
  logic [255:0] i_pmem_rdata, d_pmem_rdata, l2_wdata;
  logic i_pmem_resp, d_pmem_resp, pf_resp, l2_read, l2_write;
  logic [31:0] l2_address;
  logic [1:0] grant_owner;

  int vecs = 0;
  int miscompares = 0;
  int resp_log[$];

  l2_request_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pf_read(pf_read), .pf_address(pf_address), .pf_resp(pf_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .grant_owner(grant_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Completion order as seen by the requesters.
  always @(negedge clk) begin
    if (i_pmem_resp) resp_log.push_back(1);
    if (d_pmem_resp) resp_log.push_back(2);
    if (pf_resp)     resp_log.push_back(3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; pf_read = 0;
    i_pmem_address = IA; d_pmem_address = DA; pf_address = PA;
    d_pmem_wdata = WD; l2_rdata = '0; l2_resp = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    reset = 0;
  endtask

  // Drives one L2 completion this cycle and checks the routing to the owner.
  task automatic complete(input int own);
    logic [255:0] rd;
    rd = r256();
    l2_rdata = rd;
    l2_resp = 1;
    #1;
    chk("resp_vec", 256'({i_pmem_resp, d_pmem_resp, pf_resp}),
        256'({own == 1, own == 2, own == 3}));
    chk("i_rdata", i_pmem_rdata, (own == 1) ? rd : 256'd0);
    chk("d_rdata", d_pmem_rdata, (own == 2) ? rd : 256'd0);
    tick();
    l2_resp = 0;
  endtask

  // Arbitration rule, straight from the priority description.
  function automatic int arb(input bit ip, input bit dp, input bit pp, input int sc);
    if (ip && sc == LIMIT) return 1;
    if (dp) return 2;
    if (ip) return 1;
    if (pp && PF_EN) return 3;
    return 0;
  endfunction

  typedef struct {
    bit i, dr, dw, pf;
    int own;
    bit rd, wr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    reset = 1;
    idle_inputs();
    tbl[0] = '{1, 0, 0, 0, 1, 1, 0};
    tbl[1] = '{0, 1, 0, 0, 2, 1, 0};
    tbl[2] = '{0, 0, 1, 0, 2, 0, 1};
    tbl[3] = '{0, 1, 1, 0, 2, 0, 1};
    tbl[4] = '{1, 1, 0, 0, 2, 1, 0};
    tbl[5] = '{0, 0, 0, 1, PF_EN ? 3 : 0, PF_EN, 0};
    tbl[6] = '{1, 0, 0, 1, 1, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 1, 1, 2, 0, 1};

    // Reset state
    tick();
    chk("rst_owner", 256'(grant_owner), 256'd0);
    chk("rst_outs", 256'(|{l2_read, l2_write, l2_address, l2_wdata, i_pmem_resp,
                           d_pmem_resp, pf_resp, i_pmem_rdata, d_pmem_rdata}), 256'd0);
    reset = 0;

    // Single-request grant table
    for (int n = 0; n < 9; n++) begin
      int own;
      do_reset();
      own = tbl[n].own;
      i_pmem_read = tbl[n].i; d_pmem_read = tbl[n].dr;
      d_pmem_write = tbl[n].dw; pf_read = tbl[n].pf;
      tick();
      chk("tbl_owner", 256'(grant_owner), 256'(own));
      chk("tbl_strobe", 256'({l2_read, l2_write}), 256'({tbl[n].rd, tbl[n].wr}));
      chk("tbl_addr", 256'(l2_address),
          256'((own == 1) ? IA : (own == 2) ? DA : (own == 3) ? PA : 32'd0));
      chk("tbl_wdata", l2_wdata, (own == 2) ? WD : 256'd0);
      if (own != 0) complete(own);
      idle_inputs();
    end

    // Single I read, L2 latency 3
    do_reset();
    i_pmem_read = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("a_strobe", 256'({l2_read, l2_address}), 256'({1'b1, IA}));
      chk("a_noresp", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
    end
    tick();
    complete(1);
    i_pmem_read = 0;
    chk("a_idle", 256'({grant_owner, l2_read}), 256'd0);

    // Simultaneous D write, I read, PF read
    do_reset();
    resp_log.delete();
    i_pmem_read = 1; d_pmem_write = 1; pf_read = 1;
    tick();
    chk("b_d_owner", 256'(grant_owner), 256'd2);
    chk("b_d_write", 256'({l2_write, l2_read, l2_address}), 256'({2'b10, DA}));
    chk("b_d_wdata", l2_wdata, WD);
    complete(2);
    d_pmem_write = 0;
    chk("b_gap", 256'({l2_read, l2_write}), 256'd0);
    tick();
    chk("b_i_owner", 256'({grant_owner, l2_address}), 256'({2'd1, IA}));
    complete(1);
    i_pmem_read = 0;
    tick();
    chk("b_pf_owner", 256'(grant_owner), 256'(PF_EN ? 2'd3 : 2'd0));
    if (PF_EN) begin
      chk("b_pf_addr", 256'(l2_address), 256'(PA));
      complete(3);
    end
    pf_read = 0;
    tick();
    chk("b_nresp", 256'(resp_log.size()), 256'(PF_EN ? 3 : 2));
    chk("b_order", 256'({(resp_log.size() > 0) ? resp_log[0] : 0,
                         (resp_log.size() > 1) ? resp_log[1] : 0}), 256'({32'd2, 32'd1}));

    // Starvation: I held, D re-requesting every IDLE
    do_reset();
    i_pmem_read = 1; d_pmem_read = 1;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("c_starve_owner", 256'(grant_owner), 256'((g == 4) ? 2'd1 : 2'd2));
      complete((g == 4) ? 1 : 2);
    end
    idle_inputs();

    // Reset two cycles after the strobe in BUSY_D abandons the transaction
    do_reset();
    d_pmem_write = 1;
    tick();
    chk("e_strobe", 256'(l2_write), 256'd1);
    tick();
    tick();
    reset = 1;
    d_pmem_write = 0;
    tick();
    reset = 0;
    chk("e_owner", 256'(grant_owner), 256'd0);
    chk("e_outs", 256'(|{l2_read, l2_write, l2_address, l2_wdata, i_pmem_resp,
                         d_pmem_resp, pf_resp, i_pmem_rdata, d_pmem_rdata}), 256'd0);
    l2_rdata = r256();
    l2_resp = 1;
    #1;
    chk("e_late_resp", 256'({d_pmem_resp, d_pmem_rdata}), 256'd0);
    tick();
    l2_resp = 0;
    chk("e_still_idle", 256'(grant_owner), 256'd0);

    // Prefetch port
    do_reset();
    pf_read = 1;
    pf_address = 32'h0000_3000;
`ifdef PREFETCH_PORT_EN
    tick();
    chk("f_pf_grant", 256'({grant_owner, l2_read, l2_address}), 256'({2'd3, 1'b1, 32'h3000}));
    complete(3);
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("f_pf_off", 256'({l2_read, l2_write, pf_resp, grant_owner}), 256'd0);
    end
`endif
    idle_inputs();

    // Randomized transactions against the arbitration model
    begin
      bit ip, dp, pp, dwr, dboth;
      int sc, win, k;
      logic [31:0] ia, da, pa;
      logic [255:0] dwd;
      ip = 0; dp = 0; pp = 0; dwr = 0; dboth = 0; sc = 0;
      ia = IA; da = DA; pa = PA; dwd = WD;
      do_reset();
      for (int t = 0; t < 200; t++) begin
        if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom; end
        if (!dp && $urandom_range(0, 2) != 0) begin
          dp = 1; da = $urandom; dwd = r256();
          dwr = 1'($urandom_range(0, 1)); dboth = 1'($urandom_range(0, 1));
        end
        if (!pp && $urandom_range(0, 3) == 0) begin pp = 1; pa = $urandom; end
        i_pmem_read = ip; i_pmem_address = ia;
        d_pmem_write = dp & dwr; d_pmem_read = dp & (~dwr | dboth);
        d_pmem_address = da; d_pmem_wdata = dwd;
        pf_read = pp; pf_address = pa;
        l2_rdata = r256();
        l2_resp = ($urandom_range(0, 3) == 0);
        #1;
        chk("r_idle_resp", 256'({i_pmem_resp, d_pmem_resp, pf_resp}), 256'd0);
        win = arb(ip, dp, pp, sc);
        if (win == 2) sc = ip ? ((sc < LIMIT) ? sc + 1 : LIMIT) : 0;
        if (win == 1) sc = 0;
        tick();
        l2_resp = 0;
        chk("r_owner", 256'(grant_owner), 256'(win));
        chk("r_strobe", 256'({l2_read, l2_write}),
            256'((win == 0) ? 2'b00 : (win == 2 && dwr) ? 2'b01 : 2'b10));
        chk("r_addr", 256'(l2_address),
            256'((win == 1) ? ia : (win == 2) ? da : (win == 3) ? pa : 32'd0));
        chk("r_wdata", l2_wdata, (win == 2) ? dwd : 256'd0);
        if (win == 0) continue;
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin
          tick();
          chk("r_hold", 256'({grant_owner, l2_read | l2_write}), 256'({win[1:0], 1'b1}));
          chk("r_wait_resp", 256'({i_pmem_resp, d_pmem_resp, pf_resp}), 256'd0);
        end
        complete(win);
        if (win == 1) ip = 0;
        if (win == 2) dp = 0;
        if (win == 3) pp = 0;
        chk("r_gap", 256'({grant_owner, l2_read, l2_write}), 256'd0);
      end
      idle_inputs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
